// File: rtl/lcd_cfah_ctrl_pkg.sv
// Shared types and constants for the CFAH1602B sequencing controller.
// Holds the FSM state encoding, the HD44780 init ROM and the busy-flag bit position.
package lcd_cfah_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT_ISSUE,
        ST_INIT_XFER,
        ST_INIT_DELAY,
        ST_IDLE,
        ST_CMD_ISSUE,
        ST_CMD_XFER,
        ST_BF_ISSUE,
        ST_BF_XFER,
        ST_ERROR
    } state_e;

    localparam int C_INIT_NB = 8;
    localparam int C_IDX_W   = $clog2(C_INIT_NB);
    localparam int C_BF_BIT  = 7;

    localparam logic [C_IDX_W-1:0] C_INIT_BF_FIRST = C_IDX_W'(3);
    localparam logic [C_IDX_W-1:0] C_INIT_LAST     = C_IDX_W'(C_INIT_NB - 1);

    // Function set (x3), 2-line 5x8, display off, clear, entry mode, display on.
    localparam logic [0:C_INIT_NB-1][7:0] C_INIT_CMD = {
        8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C
    };

    // The first entries run before the busy flag is readable and are paced by fixed delays.
    function automatic logic is_delay_entry(input logic [C_IDX_W-1:0] idx);
        return idx < C_INIT_BF_FIRST;
    endfunction

endpackage

// File: rtl/lcd_cfah_ctrl_if.sv
// Byte-stream and lcd_cfah_itf transaction signals of the sequencing controller.
// slave is the controller's view; master is the upstream/interface-side view.
interface lcd_cfah_ctrl_if;
    logic [7:0] i_char_data;
    logic       i_char_rs;
    logic       i_char_valid;
    logic       o_char_ready;
    logic       o_init_done;
    logic       o_error;
    logic [7:0] o_wdata;
    logic       o_rs;
    logic       o_rw;
    logic       o_start;
    logic [7:0] i_lcd_rdata;
    logic       i_done;

    modport slave (
        input  i_char_data, i_char_rs, i_char_valid, i_lcd_rdata, i_done,
        output o_char_ready, o_init_done, o_error, o_wdata, o_rs, o_rw, o_start
    );

    modport master (
        output i_char_data, i_char_rs, i_char_valid, i_lcd_rdata, i_done,
        input  o_char_ready, o_init_done, o_error, o_wdata, o_rs, o_rw, o_start
    );
endinterface

// File: rtl/lcd_cfah_wait_cnt.sv
// Loadable down-counter; expired_o pulses for one cycle when a loaded count reaches zero.
// Comes out of reset already armed with RST_VAL so the power-on wait needs no load.
module lcd_cfah_wait_cnt #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic         armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= RST_VAL;
            armed_q <= 1'b1;
        end else if (load_i) begin
            cnt_q   <= value_i;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) armed_q <= 1'b0;
            else             cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_cfah_ctrl.sv
// CFAH1602B sequencing controller: power-on init, then one lcd_cfah_itf write per
// accepted byte followed by busy-flag polling until the display reports ready.
module lcd_cfah_ctrl
    import lcd_cfah_ctrl_pkg::*;
#(
    parameter int G_PWR_WAIT_CYCLES = 750000,
    parameter int G_WAIT1_CYCLES    = 205000,
    parameter int G_WAIT2_CYCLES    = 5000,
    parameter int G_BF_MAX_POLL     = 1024
) (
    input  logic            clk,
    input  logic            rst,
    lcd_cfah_ctrl_if.slave  bus
);

    localparam int C_MAX_A = (G_PWR_WAIT_CYCLES > G_WAIT1_CYCLES) ? G_PWR_WAIT_CYCLES : G_WAIT1_CYCLES;
    localparam int C_MAX   = (C_MAX_A > G_WAIT2_CYCLES) ? C_MAX_A : G_WAIT2_CYCLES;
    localparam int CW      = (C_MAX > 1) ? $clog2(C_MAX) : 1;
    localparam int PW      = $clog2(G_BF_MAX_POLL + 1);

    state_e               state_q, state_d;
    logic [C_IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [PW-1:0]        poll_q, poll_d, poll_inc;
    logic                 init_done_q, init_done_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 rs_q, rs_d;
    logic                 rw_q, rw_d;
    logic                 ld;
    logic [CW-1:0]        ld_val;
    logic                 expired;

    lcd_cfah_wait_cnt #(
        .W       (CW),
        .RST_VAL (CW'(G_PWR_WAIT_CYCLES - 1))
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ld),
        .value_i   (ld_val),
        .expired_o (expired)
    );

    assign idx_nxt  = idx_q + 1'b1;
    assign poll_inc = poll_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        init_done_d = init_done_q;
        wdata_d     = wdata_q;
        rs_d        = rs_q;
        rw_d        = rw_q;
        ld          = 1'b0;
        ld_val      = '0;
        unique case (state_q)
            ST_PWR_WAIT: if (expired) begin
                idx_d   = '0;
                wdata_d = C_INIT_CMD[0];
                rs_d    = 1'b0;
                rw_d    = 1'b0;
                state_d = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: state_d = ST_INIT_XFER;
            ST_INIT_XFER: if (bus.i_done) begin
                if (is_delay_entry(idx_q)) begin
                    ld      = 1'b1;
                    ld_val  = (idx_q == '0) ? CW'(G_WAIT1_CYCLES - 1) : CW'(G_WAIT2_CYCLES - 1);
                    state_d = ST_INIT_DELAY;
                end else begin
                    poll_d  = '0;
                    wdata_d = 8'h00;
                    rs_d    = 1'b0;
                    rw_d    = 1'b1;
                    state_d = ST_BF_ISSUE;
                end
            end
            ST_INIT_DELAY: if (expired) begin
                idx_d   = idx_nxt;
                wdata_d = C_INIT_CMD[idx_nxt];
                rs_d    = 1'b0;
                rw_d    = 1'b0;
                state_d = ST_INIT_ISSUE;
            end
            // Byte latch lives directly in the output registers; they stay put through the write.
            ST_IDLE: if (bus.i_char_valid) begin
                wdata_d = bus.i_char_data;
                rs_d    = bus.i_char_rs;
                rw_d    = 1'b0;
                state_d = ST_CMD_ISSUE;
            end
            ST_CMD_ISSUE: state_d = ST_CMD_XFER;
            ST_CMD_XFER: if (bus.i_done) begin
                poll_d  = '0;
                wdata_d = 8'h00;
                rs_d    = 1'b0;
                rw_d    = 1'b1;
                state_d = ST_BF_ISSUE;
            end
            ST_BF_ISSUE: state_d = ST_BF_XFER;
            ST_BF_XFER: if (bus.i_done) begin
                if (bus.i_lcd_rdata[C_BF_BIT]) begin
                    poll_d  = poll_inc;
                    state_d = (poll_inc == PW'(G_BF_MAX_POLL)) ? ST_ERROR : ST_BF_ISSUE;
                end else if (!init_done_q) begin
                    if (idx_q == C_INIT_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_nxt;
                        wdata_d = C_INIT_CMD[idx_nxt];
                        rs_d    = 1'b0;
                        rw_d    = 1'b0;
                        state_d = ST_INIT_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWR_WAIT;
            idx_q       <= '0;
            poll_q      <= '0;
            init_done_q <= 1'b0;
            wdata_q     <= 8'h00;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            init_done_q <= init_done_d;
            wdata_q     <= wdata_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
        end
    end

    assign bus.o_start      = (state_q == ST_INIT_ISSUE) || (state_q == ST_CMD_ISSUE) ||
                              (state_q == ST_BF_ISSUE);
    assign bus.o_char_ready = (state_q == ST_IDLE);
    assign bus.o_error      = (state_q == ST_ERROR);
    assign bus.o_init_done  = init_done_q;
    assign bus.o_wdata      = wdata_q;
    assign bus.o_rs         = rs_q;
    assign bus.o_rw         = rw_q;

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Bench for lcd_cfah_ctrl: a behavioural lcd_cfah_itf responder with a scripted busy flag,
// and a write scoreboard filled as bytes are offered and drained as writes appear.
module tb_lcd_cfah_ctrl;
    localparam int P   = 100;
    localparam int W1  = 40;
    localparam int W2  = 10;
    localparam int MP  = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_cfah_ctrl_if bus();

    lcd_cfah_ctrl #(
        .G_PWR_WAIT_CYCLES (P),
        .G_WAIT1_CYCLES    (W1),
        .G_WAIT2_CYCLES    (W2),
        .G_BF_MAX_POLL     (MP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, expv);
        end
    endtask

    logic [7:0] init_seq [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    logic [8:0] wq [$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int rel_cyc = 0;
    bit first_pend = 0;
    int wr_idx = 0;
    int done0_cyc = 0;
    int cmd_reads = 0;
    int bf_busy_left = 0;
    bit bf_stuck = 0;
    int tot_starts = 0;

    // Behavioural lcd_cfah_itf: i_done LAT cycles after o_start, busy flag from the script.
    initial begin
        int pending;
        logic x_rw, x_rs, bf;
        logic [7:0] x_d;
        logic [8:0] e;
        int x_idx;
        pending = 0;
        x_idx = 0;
        bus.i_done = 1'b0;
        bus.i_lcd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
                bus.i_done = 1'b0;
                bus.i_lcd_rdata = 8'h00;
            end else begin
                bus.i_done = 1'b0;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        chk("hold", {22'b0, bus.o_rs, bus.o_rw, bus.o_wdata}, {22'b0, x_rs, x_rw, x_d});
                        if (x_rw) begin
                            bf = bf_stuck || (bf_busy_left > 0);
                            if (bf_busy_left > 0) bf_busy_left--;
                            bus.i_lcd_rdata = {bf, 7'h05};
                        end else begin
                            bus.i_lcd_rdata = 8'h00;
                        end
                        bus.i_done = 1'b1;
                        if (!x_rw && x_idx == 0) done0_cyc = cyc;
                    end
                end else if (bus.o_start) begin
                    x_rw = bus.o_rw;
                    x_rs = bus.o_rs;
                    x_d  = bus.o_wdata;
                    pending = LAT;
                    tot_starts++;
                    if (first_pend) begin
                        first_pend = 0;
                        chk("first_start_edge", cyc - rel_cyc + 1, P + 1);
                    end
                    if (!x_rw) begin
                        x_idx = wr_idx;
                        wr_idx++;
                        if (x_idx == 1) chk("delay0_gap", cyc - done0_cyc, W1 + 1);
                        if (wq.size() == 0) begin
                            chk("unexp_write", {23'b0, x_rs, x_d}, 32'hFFFF_FFFF);
                        end else begin
                            e = wq.pop_front();
                            chk("write", {23'b0, x_rs, x_d}, {23'b0, e});
                        end
                    end else begin
                        cmd_reads++;
                        chk("bf_read_bus", {23'b0, x_rs, x_d}, 32'h0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {19'b0, bus.o_char_ready, bus.o_init_done, bus.o_error, bus.o_wdata,
                            bus.o_rs, bus.o_rw, bus.o_start}, 32'h0);
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back({1'b0, init_seq[i]});
        wr_idx = 0;
        first_pend = 1;
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.o_char_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, bus.o_char_ready}, 32'h1);
    endtask

    task automatic offer(input logic [7:0] d, input logic rs);
        cmd_reads = 0;
        wq.push_back({rs, d});
        bus.i_char_data  = d;
        bus.i_char_rs    = rs;
        bus.i_char_valid = 1'b1;
        wait_ready(100, "accept_wait");
        @(negedge clk);
        bus.i_char_valid = 1'b0;
        chk("ready_drop", {31'b0, bus.o_char_ready}, 32'h0);
    endtask

    initial begin
        int n;
        int starts_snap;
        bus.i_char_data  = 8'h42;
        bus.i_char_rs    = 1'b1;
        bus.i_char_valid = 1'b1;

        // Power-on with a byte already waiting: it must follow the whole init ROM.
        do_reset();
        wq.push_back({1'b1, 8'h42});
        chk("init_done_low", {31'b0, bus.o_init_done}, 32'h0);
        n = 0;
        while (!(bus.o_char_ready && bus.i_char_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_ready", {31'b0, bus.o_char_ready}, 32'h1);
        chk("init_done_with_ready", {31'b0, bus.o_init_done}, 32'h1);
        chk("init_writes", wr_idx, 8);
        @(negedge clk);
        bus.i_char_valid = 1'b0;
        wait_ready(200, "early_cmd_done");
        chk("early_sb_empty", wq.size(), 0);

        // Data write, busy clears immediately.
        offer(8'h41, 1'b1);
        wait_ready(200, "char_done");
        chk("char_reads", cmd_reads, 1);
        chk("char_error", {31'b0, bus.o_error}, 32'h0);

        // Busy for three reads, clear on the fourth.
        bf_busy_left = 3;
        offer(8'h48, 1'b1);
        wait_ready(200, "poll_done");
        chk("poll_reads", cmd_reads, 4);
        chk("poll_error", {31'b0, bus.o_error}, 32'h0);

        // Instruction write with one busy read.
        bf_busy_left = 1;
        offer(8'h80, 1'b0);
        wait_ready(200, "instr_done");
        chk("instr_reads", cmd_reads, 2);
        chk("sb_empty_1", wq.size(), 0);

        // Busy stuck: timeout after exactly MP reads, then terminal.
        bf_stuck = 1;
        offer(8'h55, 1'b1);
        n = 0;
        while (!bus.o_error && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_error", {31'b0, bus.o_error}, 32'h1);
        chk("timeout_reads", cmd_reads, MP);
        chk("timeout_ready", {31'b0, bus.o_char_ready}, 32'h0);
        starts_snap = tot_starts;
        bus.i_char_valid = 1'b1;
        repeat (30) @(negedge clk);
        bus.i_char_valid = 1'b0;
        chk("error_sticky", {30'b0, bus.o_error, bus.o_char_ready}, 32'h2);
        chk("error_quiet", tot_starts, starts_snap);
        bf_stuck = 0;

        // Recover by reset, then reset again in the middle of a command write.
        do_reset();
        wait_ready(2000, "reinit_ready");
        chk("reinit_done", {31'b0, bus.o_init_done}, 32'h1);
        chk("sb_empty_2", wq.size(), 0);
        offer(8'h31, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {19'b0, bus.o_char_ready, bus.o_init_done, bus.o_error, bus.o_wdata,
                          bus.o_rs, bus.o_rw, bus.o_start}, 32'h0);
        chk("mid_sb_empty", wq.size(), 0);
        do_reset();
        chk("rerun_done_low", {31'b0, bus.o_init_done}, 32'h0);
        wait_ready(2000, "rerun_ready");
        chk("rerun_done", {31'b0, bus.o_init_done}, 32'h1);
        chk("rerun_writes", wr_idx, 8);
        chk("sb_empty_3", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_cfah_ctrl.md
# lcd_cfah_ctrl

Sequencing controller that sits directly upstream of `lcd_cfah_itf`. It runs the HD44780-compatible power-on initialisation of the CFAH1602B display. It then accepts instruction or character bytes on a valid/ready handshake and issues each one as a single `lcd_cfah_itf` transaction (`o_start`/`i_done`). After every write it polls the busy flag through `lcd_cfah_itf` read transactions before accepting the next byte.

## Interface
- `G_PWR_WAIT_CYCLES`, 750000, clk cycles from reset release to the first init command (15 ms @ 50 MHz).
- `G_WAIT1_CYCLES`, 205000, delay after init entry 0 (4.1 ms).
- `G_WAIT2_CYCLES`, 5000, delay after init entries 1 and 2 (100 µs).
- `G_BF_MAX_POLL`, 1024, maximum busy-flag reads per command before error.
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_char_data`  in  8  byte to send (instruction or DDRAM data).
- `i_char_rs`  in  1  0 = instruction, 1 = data.
- `i_char_valid`  in  1  byte available.
- `o_char_ready`  out  1  controller can accept a byte.
- `o_init_done`  out  1  init sequence complete; sticky until reset.
- `o_error`  out  1  busy-flag timeout; sticky until reset.
- `o_wdata`  out  8  to `lcd_cfah_itf` `i_wdata`.
- `o_rs`  out  1  to `lcd_cfah_itf` `i_rs`.
- `o_rw`  out  1  to `lcd_cfah_itf` `i_rw` (1 = read).
- `o_start`  out  1  one-cycle transaction request.
- `i_lcd_rdata`  in  8  from `lcd_cfah_itf` `o_lcd_rdata`; valid in the cycle `i_done` = 1.
- `i_done`  in  1  one-cycle transaction-complete pulse.

## Operation
- **Init ROM**, 8 entries, all with rs = 0, rw = 0: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C.
- Entries 0–2 are delay-paced: wait for `i_done`, then G_WAIT1 (entry 0) or G_WAIT2 (entries 1, 2).
- Entries 3–7 are busy-flag-paced.
- **States:**
  - PWR_WAIT → INIT_ISSUE when the counter expires.
  - INIT_ISSUE: pulse `o_start` → INIT_XFER.
  - INIT_XFER, on `i_done`:
    - delay entry → INIT_DELAY, which returns to INIT_ISSUE (next entry) on expiry;
    - BF entry → BF_ISSUE.
  - IDLE: `o_char_ready` = 1. On valid & ready: latch byte and rs → CMD_ISSUE.
  - CMD_ISSUE: pulse `o_start` with rw = 0 → CMD_XFER.
  - CMD_XFER → BF_ISSUE on `i_done`.
  - BF_ISSUE: pulse `o_start` with rs = 0, rw = 1, `o_wdata` = 0x00 → BF_XFER.
  - BF_XFER, on `i_done`:
    - `i_lcd_rdata[7]` = 1: increment poll count; if count = G_BF_MAX_POLL → ERROR, else → BF_ISSUE.
    - `i_lcd_rdata[7]` = 0: after the last init entry, set `o_init_done` and go to IDLE; during init, go to INIT_ISSUE (next entry); otherwise go to IDLE.
  - ERROR: terminal. `o_error` = 1, `o_char_ready` = 0.
- The poll counter clears on every BF_ISSUE entered from CMD_XFER or INIT_XFER.
- `o_wdata`/`o_rs`/`o_rw` are held stable from the `o_start` cycle until the `i_done` cycle.
- `i_done` is ignored in any state other than *_XFER.
- `i_char_valid` during init, XFER, or BF states is not accepted. The upstream holds the byte; no drop, no queue.

## Timing
- **Reset values:** all outputs 0; state PWR_WAIT; counter loaded with G_PWR_WAIT_CYCLES−1.
- **Assertion of `rst` at any time** forces reset values immediately (asynchronously). Deassertion restarts the full init sequence.
- **First `o_start`:** G_PWR_WAIT_CYCLES+1 rising edges after `rst` falls.
- **Delay entries:** next `o_start` comes G_WAITx+1 cycles after the `i_done` cycle.
- **Accept → write:** `o_start` is asserted the cycle after the accept edge. `o_char_ready` drops in that same cycle.
- **Busy-flag read:** `o_start` follows 1 cycle after `i_done`.
- **Back in IDLE:** `o_char_ready` = 1 the cycle after the final `i_done` with BF = 0.
- **`o_init_done`** rises in the same cycle `o_char_ready` first rises.
- **Counter width:** $clog2 of the largest wait parameter. Poll counter width: $clog2(G_BF_MAX_POLL+1).

## Structure
- **`lcd_cfah_ctrl_pkg`:**
  - state enum;
  - init ROM constants (`C_INIT_CMD` array, `C_INIT_NB` = 8, `C_INIT_BF_FIRST` = 3);
  - `C_BF_BIT` = 7.
- **`lcd_cfah_wait_cnt`:** loadable down-counter sub-module with `load`, `value`, and `expired` pulse. Used for PWR_WAIT and INIT_DELAY.
- The FSM, byte latch and poll counter stay in `lcd_cfah_ctrl`.

## Test plan
All scenarios use G_PWR_WAIT_CYCLES = 100, G_WAIT1_CYCLES = 40, G_WAIT2_CYCLES = 10, G_BF_MAX_POLL = 4, and `lcd_cfah_ctrl` driving `lcd_cfah_itf` + `LCD_CFAH_emul`.

1. **Power-on:** release `rst` → first `o_start` on edge 101 with `o_wdata` = 0x30, rs = 0, rw = 0. Then the emulator collects 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C. The gap between write 0 `i_done` and write 1 `o_start` is 41 cycles. `o_init_done` = 1.
2. **Character write:** after init, `i_char_data` = 0x41, rs = 1, valid = 1 → one write of 0x41 with rs = 1, then at least one read with rw = 1, then `o_char_ready` = 1. Emulator `o_rdata` = 0x41.
3. **Busy polling:** emulator returns BF = 1 for 3 reads, then 0 → exactly 4 reads, then IDLE; `o_error` = 0.
4. **Busy timeout:** BF stuck at 1 → exactly 4 reads, then `o_error` = 1, `o_char_ready` = 0 indefinitely.
5. **Early valid:** `i_char_valid` = 1 with 0x42 held from reset → not accepted before `o_init_done`. 0x42 is written exactly once, after 0x0C.
6. **Reset mid-operation:** assert `rst` during a CMD_XFER → all outputs 0 the same cycle. After release, the init sequence repeats from 0x30 with `o_init_done` = 0.
